sha256_stream: RTL and testbench

Parametrised SHA-224/SHA-256 streaming hash engine that absorbs a byte-granular message over a D_WIDTH-bit valid/ready stream. It performs FIPS 180-4 padding and length encoding in hardware and returns the digest on a valid/ready output port. It sits between a DMA/stream source and the crypto result FIFO, so software never pre-pads messages.

---
 rtl/sha256_stream.sv | 199 +++++++++++++++++++
 tb/tb_sha256_stream.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - streaming SHA-224/SHA-256 engine with in-hardware message padding
module sha256_stream #(
   parameter int D_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 in_mode_i,
   input  logic [D_WIDTH-1:0]   in_data_i,
   input  logic [D_WIDTH/8-1:0] in_keep_i,
   input  logic                 in_last_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [255:0]         out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);
   localparam int L  = 512 / D_WIDTH;
   localparam int NB = D_WIDTH / 8;
   localparam int PW = $clog2(L);
   localparam int CW = $clog2(NB + 1);
   localparam logic [PW-1:0] LAST_LANE = PW'(L - 1);

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                         32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PAD, S_ROUND, S_FOLD, S_OUT} state_t;
   state_t state_q, state_d;

   logic          mode_q, last_seen_q, need80_q, second_q, out_valid_q;
   logic [31:0]   h_q [8];
   logic [31:0]   wv_q [8];
   logic [31:0]   h_new [8];
   logic [511:0]  blk_q;
   logic [63:0]   bitcnt_q, cnt_base, cnt_add;
   logic [PW-1:0] lane_q;
   logic [5:0]    rnd_q;
   logic [255:0]  out_data_q, digest;
   logic [CW-1:0] nbytes;
   logic          run, accept;
   int            off80;
   logic [D_WIDTH-1:0] lane_be, pad_be;
   logic [31:0]   w0, w1, w9, w14, ws0, ws1, w_new, s0_a, s1_e, ch, maj, t1, t2;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_ABSORB);
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   // Last-beat byte count is the run of ones from keep bit 0; higher bits are ignored.
   always_comb begin
      nbytes = '0;
      run    = 1'b1;
      for (int j = 0; j < NB; j++) begin
         if (run && in_keep_i[j]) nbytes = nbytes + 1'b1;
         else                     run = 1'b0;
      end
      lane_be = '0;
      for (int j = 0; j < NB; j++) begin
         if (!in_last_i || j < int'(nbytes)) lane_be[D_WIDTH-1-8*j -: 8] = in_data_i[8*j +: 8];
         else if (j == int'(nbytes))         lane_be[D_WIDTH-1-8*j -: 8] = 8'h80;
      end
      pad_be   = need80_q ? {8'h80, {(D_WIDTH-8){1'b0}}} : '0;
      off80    = int'(lane_q) * NB + int'(nbytes);
      cnt_base = (state_q == S_IDLE) ? 64'd0 : bitcnt_q;
      cnt_add  = in_last_i ? {{(61-CW){1'b0}}, nbytes, 3'b000} : 64'(D_WIDTH);
   end

   // Block buffer doubles as the message schedule: its top word is always W[t].
   always_comb begin
      w0    = blk_q[511:480];
      w1    = blk_q[479:448];
      w9    = blk_q[223:192];
      w14   = blk_q[63:32];
      ws0   = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
      ws1   = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
      w_new = ws1 + w9 + ws0 + w0;
      s1_e  = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
      ch    = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
      t1    = wv_q[7] + s1_e + ch + K[rnd_q] + w0;
      s0_a  = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
      maj   = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
      t2    = s0_a + maj;
      for (int i = 0; i < 8; i++) h_new[i] = h_q[i] + wv_q[i];
      digest = mode_q ? {h_new[0], h_new[1], h_new[2], h_new[3], h_new[4], h_new[5], h_new[6], h_new[7]}
                      : {32'h0, h_new[0], h_new[1], h_new[2], h_new[3], h_new[4], h_new[5], h_new[6]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_ABSORB: begin
            if (accept) begin
               if (lane_q == LAST_LANE) state_d = S_ROUND;
               else if (in_last_i)      state_d = S_PAD;
               else                     state_d = S_ABSORB;
            end
         end
         S_PAD:   if (lane_q == LAST_LANE) state_d = S_ROUND;
         S_ROUND: if (rnd_q == 6'd63) state_d = S_FOLD;
         S_FOLD: begin
            if (!last_seen_q)  state_d = S_ABSORB;
            else if (second_q) state_d = S_PAD;
            else               state_d = S_OUT;
         end
         S_OUT:   if (out_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mode_q      <= 1'b0;
         last_seen_q <= 1'b0;
         need80_q    <= 1'b0;
         second_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         blk_q       <= '0;
         bitcnt_q    <= '0;
         lane_q      <= '0;
         rnd_q       <= '0;
         for (int i = 0; i < 8; i++) begin
            h_q[i]  <= '0;
            wv_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE, S_ABSORB: begin
               if (accept) begin
                  blk_q[511 - int'(lane_q)*D_WIDTH -: D_WIDTH] <= lane_be;
                  lane_q      <= lane_q + 1'b1;
                  last_seen_q <= in_last_i;
                  bitcnt_q    <= cnt_base + cnt_add;
                  if (in_last_i) begin
                     need80_q <= (int'(nbytes) == NB);
                     second_q <= (off80 >= 56);
                  end
                  if (state_q == S_IDLE) begin
                     mode_q <= in_mode_i;
                     for (int i = 0; i < 8; i++) h_q[i] <= in_mode_i ? IV256[i] : IV224[i];
                  end
                  if (lane_q == LAST_LANE) for (int i = 0; i < 8; i++) wv_q[i] <= h_q[i];
               end
            end
            S_PAD: begin
               blk_q[511 - int'(lane_q)*D_WIDTH -: D_WIDTH] <= pad_be;
               need80_q <= 1'b0;
               lane_q   <= lane_q + 1'b1;
               if (lane_q == LAST_LANE) begin
                  for (int i = 0; i < 8; i++) wv_q[i] <= h_q[i];
                  if (!second_q) blk_q[63:0] <= bitcnt_q;
               end
            end
            S_ROUND: begin
               wv_q[0] <= t1 + t2;
               wv_q[1] <= wv_q[0];
               wv_q[2] <= wv_q[1];
               wv_q[3] <= wv_q[2];
               wv_q[4] <= wv_q[3] + t1;
               wv_q[5] <= wv_q[4];
               wv_q[6] <= wv_q[5];
               wv_q[7] <= wv_q[6];
               blk_q   <= {blk_q[479:0], w_new};
               rnd_q   <= rnd_q + 1'b1;
            end
            S_FOLD: begin
               for (int i = 0; i < 8; i++) h_q[i] <= h_new[i];
               if (last_seen_q && second_q) second_q <= 1'b0;
               else if (last_seen_q) begin
                  out_data_q  <= digest;
                  out_valid_q <= 1'b1;
               end
            end
            S_OUT: if (out_ready_i) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_stream.sv
// tb/tb_sha256_stream.sv - scoreboard bench for sha256_stream at D_WIDTH 64 and 32
module tb_sha256_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         mode64 = 1'b1, last64 = 1'b0, valid64 = 1'b0, ready64, ovalid64, oready64 = 1'b1;
   logic [63:0]  data64 = '0;
   logic [7:0]   keep64 = '0;
   logic [255:0] odata64;
   logic         mode32 = 1'b1, last32 = 1'b0, valid32 = 1'b0, ready32, ovalid32, oready32 = 1'b1;
   logic [31:0]  data32 = '0;
   logic [3:0]   keep32 = '0;
   logic [255:0] odata32;

   sha256_stream #(.D_WIDTH(64)) dut64 (
      .clk_i(clk), .rst_n_i(rst_n), .in_mode_i(mode64), .in_data_i(data64), .in_keep_i(keep64),
      .in_last_i(last64), .in_valid_i(valid64), .in_ready_o(ready64), .out_data_o(odata64),
      .out_valid_o(ovalid64), .out_ready_i(oready64));

   sha256_stream #(.D_WIDTH(32)) dut32 (
      .clk_i(clk), .rst_n_i(rst_n), .in_mode_i(mode32), .in_data_i(data32), .in_keep_i(keep32),
      .in_last_i(last32), .in_valid_i(valid32), .in_ready_o(ready32), .out_data_o(odata32),
      .out_valid_o(ovalid32), .out_ready_i(oready32));

   localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] ABC224 = {32'h0, 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7};
   localparam logic [255:0] LONG256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam string LONG_MSG = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

   int checks = 0;
   int failures = 0;
   logic [255:0] exp64_q [$];
   logic [255:0] exp32_q [$];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Digest comparisons happen on the handshake cycle against the oldest pushed expectation.
   always @(negedge clk) begin
      if (rst_n && ovalid64 && oready64) begin
         if (exp64_q.size() == 0) check_eq("digest64_unexpected", 1, 0);
         else check_eq("digest64", odata64, exp64_q.pop_front());
      end
      if (rst_n && ovalid32 && oready32) begin
         if (exp32_q.size() == 0) check_eq("digest32_unexpected", 1, 0);
         else check_eq("digest32", odata32, exp32_q.pop_front());
      end
   end

   task automatic put_beat(input bit w32, input logic [63:0] d, input logic [7:0] k, input bit l,
                           input bit m, input bit gap);
      int guard;
      int n;
      if (gap) begin
         n = $urandom_range(0, 3);
         repeat (n) begin @(posedge clk); #1; end
      end
      if (w32) begin
         mode32 = m; data32 = d[31:0]; keep32 = k[3:0]; last32 = l; valid32 = 1'b1;
      end else begin
         mode64 = m; data64 = d; keep64 = k; last64 = l; valid64 = 1'b1;
      end
      guard = 0;
      @(negedge clk);
      while (!(w32 ? ready32 : ready64) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) check_eq("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      valid32 = 1'b0; last32 = 1'b0; valid64 = 1'b0; last64 = 1'b0;
   endtask

   task automatic send_msg(input bit w32, input string s, input bit m, input bit gap,
                           input bit push, input logic [255:0] exp);
      int nb, n, nbeats, rem;
      logic [63:0] d;
      logic [7:0]  k;
      nb = w32 ? 4 : 8;
      n = s.len();
      nbeats = (n == 0) ? 1 : (n + nb - 1) / nb;
      if (push) begin
         if (w32) exp32_q.push_back(exp);
         else     exp64_q.push_back(exp);
      end
      for (int b = 0; b < nbeats; b++) begin
         d = '0;
         for (int j = 0; j < nb; j++) if (b*nb + j < n) d[8*j +: 8] = s[b*nb + j];
         rem = n - b*nb;
         if (rem >= nb) k = w32 ? 8'h0f : 8'hff;
         else           k = 8'((1 << rem) - 1);
         put_beat(w32, d, k, b == nbeats - 1, m, gap);
      end
   endtask

   task automatic wait_valid(input bit w32, input int lat, input string tag);
      int n;
      n = 0;
      while (!(w32 ? ovalid32 : ovalid64) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (lat >= 0) check_eq(tag, n, lat);
      else if (n >= 2000) check_eq("valid_timeout", 0, 1);
   endtask

   task automatic wait_done(input bit w32);
      int n;
      n = 0;
      while ((w32 ? ovalid32 : ovalid64) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("handshake_done", w32 ? ovalid32 : ovalid64, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready64", ready64, 1);
      check_eq("rst_valid64", ovalid64, 0);
      check_eq("rst_data64", odata64, 0);
      check_eq("rst_ready32", ready32, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send_msg(0, "abc", 1, 0, 1, ABC256);
      wait_valid(0, 72, "lat_abc64");
      wait_done(0);

      send_msg(0, "", 1, 0, 1, EMPTY256);
      wait_valid(0, 72, "lat_empty64");
      wait_done(0);

      send_msg(0, "abc", 0, 0, 1, ABC224);
      wait_valid(0, -1, "");
      wait_done(0);

      send_msg(0, LONG_MSG, 1, 0, 1, LONG256);
      wait_valid(0, 139, "lat_long64");
      wait_done(0);

      send_msg(1, LONG_MSG, 1, 0, 1, LONG256);
      wait_valid(1, 148, "lat_long32");
      wait_done(1);

      send_msg(1, "abc", 1, 1, 1, ABC256);
      wait_valid(1, -1, "");
      wait_done(1);

      send_msg(0, "abc", 1, 1, 1, ABC256);
      wait_valid(0, -1, "");
      wait_done(0);

      oready64 = 1'b0;
      send_msg(0, "abc", 1, 0, 1, ABC256);
      wait_valid(0, -1, "");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("stall_valid", ovalid64, 1);
         check_eq("stall_data", odata64, ABC256);
         check_eq("stall_ready", ready64, 0);
      end
      @(posedge clk);
      #1;
      oready64 = 1'b1;
      wait_done(0);

      send_msg(0, "abc", 1, 0, 1, ABC256);
      send_msg(0, "", 1, 0, 1, EMPTY256);
      wait_valid(0, -1, "");
      wait_done(0);

      // Abort a message with reset while the round counter reads 30.
      send_msg(0, "abc", 1, 0, 0, '0);
      repeat (37) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_ready", ready64, 1);
      check_eq("midrst_valid", ovalid64, 0);
      check_eq("midrst_data", odata64, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_msg(0, "abc", 1, 0, 1, ABC256);
      wait_valid(0, 72, "lat_after_rst");
      wait_done(0);

      repeat (3) @(posedge clk);
      check_eq("queue64_empty", exp64_q.size(), 0);
      check_eq("queue32_empty", exp32_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
